// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encoding, constants and bit-serial CRC helper for adc_frame_capture
package adc_pkg;

  localparam int          ADC_STATUS_BITS = 16;
  localparam int          CHAN_W          = 2;
  localparam logic [15:0] CRC_POLY        = 16'h1021;
  localparam logic [15:0] CRC_INIT        = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS,
    ST_CHAN,
    ST_CRC,
    ST_DONE
  } cap_state_e;

  // One CRC-CCITT step, MSB-first, non-reflected.
  function automatic logic [15:0] crc_ccitt_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - synchronous FIFO with wrap-bit pointers; head is read combinationally
module adc_sample_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - snoops the SPI bus and assembles ADS131A0x frames into a sample FIFO
// Optional trailing CRC word check is enabled by defining ADC_CRC_EN.
module adc_frame_capture
  import adc_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_BITS    = 24,
  parameter int OUT_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                       system_clock,
  input  logic                       reset,
  input  logic                       spi_sclk,
  input  logic                       spi_cs,
  input  logic                       spi_miso,
  output logic [OUT_WIDTH-1:0]       sample_data,
  output logic [CHAN_W-1:0]          sample_chan,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic [ADC_STATUS_BITS-1:0] status_word,
  output logic                       frame_done,
  output logic                       frame_error,
  output logic                       overflow,
  output logic                       crc_error
);

  localparam int                BIT_W     = $clog2(WORD_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);
  localparam logic [CHAN_W-1:0] LAST_WORD = CHAN_W'(NUM_CHANNELS - 1);
  localparam int                ENTRY_W   = CHAN_W + OUT_WIDTH;

  logic sclk_q, sclk_prev_q, cs_q, cs_prev_q, miso_q;

  cap_state_e                 state_q, state_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [CHAN_W-1:0]          word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0]       shift_q, shift_d;
  logic [ADC_STATUS_BITS-1:0] pend_status_q, pend_status_d;
  logic [ADC_STATUS_BITS-1:0] status_word_q, status_word_d;
  logic                       frame_done_q, frame_done_d;
  logic                       frame_error_q, frame_error_d;
  logic                       push_q, push_d;
  logic [CHAN_W-1:0]          push_chan_q, push_chan_d;
  logic                       overflow_q, overflow_d;
`ifdef ADC_CRC_EN
  logic [15:0]                crc_q, crc_d;
  logic                       crc_error_q, crc_error_d;
`endif

  logic                        sclk_fall, cs_fall, cs_rise, word_last, in_frame;
  logic [WORD_BITS-1:0]        word_full;
  logic signed [WORD_BITS-1:0] shift_s;
  logic [OUT_WIDTH-1:0]        sample_sext;
  logic [ENTRY_W-1:0]          fifo_head;
  logic                        fifo_full, fifo_empty, fifo_pop, fifo_drop;

  assign sclk_fall = sclk_prev_q && !sclk_q && !cs_q;
  assign cs_fall   = cs_prev_q && !cs_q;
  assign cs_rise   = !cs_prev_q && cs_q;
  assign word_full = {shift_q[WORD_BITS-2:0], miso_q};
  assign word_last = sclk_fall && (bit_cnt_q == LAST_BIT);
  assign in_frame  = state_q inside {ST_STATUS, ST_CHAN, ST_CRC};

  // The push happens the cycle after the last edge, when shift_q already holds the whole word.
  assign shift_s     = shift_q;
  assign sample_sext = OUT_WIDTH'(shift_s);

  assign fifo_pop  = !fifo_empty && sample_ready;
  assign fifo_drop = push_q && fifo_full && !fifo_pop;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    shift_d       = shift_q;
    pend_status_d = pend_status_q;
    status_word_d = status_word_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    push_d        = 1'b0;
    push_chan_d   = push_chan_q;
    overflow_d    = overflow_q | fifo_drop;
`ifdef ADC_CRC_EN
    crc_d         = crc_q;
    crc_error_d   = 1'b0;
`endif

    if (sclk_fall) begin
      shift_d = word_full;
    end
    if (sclk_fall && in_frame) begin
      bit_cnt_d = word_last ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = ST_STATUS;
`ifdef ADC_CRC_EN
          crc_d      = CRC_INIT;
`endif
        end
      end
      ST_STATUS: begin
`ifdef ADC_CRC_EN
        if (sclk_fall) crc_d = crc_ccitt_bit(crc_q, miso_q);
`endif
        if (word_last) begin
          pend_status_d = word_full[WORD_BITS-1 -: ADC_STATUS_BITS];
          state_d       = ST_CHAN;
        end
      end
      ST_CHAN: begin
`ifdef ADC_CRC_EN
        if (sclk_fall) crc_d = crc_ccitt_bit(crc_q, miso_q);
`endif
        if (word_last) begin
          push_d      = 1'b1;
          push_chan_d = word_cnt_q;
          word_cnt_d  = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
`ifdef ADC_CRC_EN
            state_d       = ST_CRC;
`else
            state_d       = ST_DONE;
            frame_done_d  = 1'b1;
            status_word_d = pend_status_q;
`endif
          end
        end
      end
`ifdef ADC_CRC_EN
      ST_CRC: begin
        if (word_last) begin
          state_d       = ST_DONE;
          frame_done_d  = 1'b1;
          status_word_d = pend_status_q;
          crc_error_d   = (word_full[WORD_BITS-1 -: 16] != crc_q);
        end
      end
`endif
      ST_DONE: begin
        if (cs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // CS can only rise while no SCLK edge is counted, so this never races a push.
    if (cs_rise && in_frame) begin
      frame_error_d = 1'b1;
      state_d       = ST_IDLE;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      sclk_q        <= 1'b0;
      sclk_prev_q   <= 1'b0;
      cs_q          <= 1'b0;
      cs_prev_q     <= 1'b0;
      miso_q        <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      shift_q       <= '0;
      pend_status_q <= '0;
      status_word_q <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      push_q        <= 1'b0;
      push_chan_q   <= '0;
      overflow_q    <= 1'b0;
`ifdef ADC_CRC_EN
      crc_q         <= CRC_INIT;
      crc_error_q   <= 1'b0;
`endif
    end else begin
      sclk_q        <= spi_sclk;
      sclk_prev_q   <= sclk_q;
      cs_q          <= spi_cs;
      cs_prev_q     <= cs_q;
      miso_q        <= spi_miso;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shift_q       <= shift_d;
      pend_status_q <= pend_status_d;
      status_word_q <= status_word_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      push_q        <= push_d;
      push_chan_q   <= push_chan_d;
      overflow_q    <= overflow_d;
`ifdef ADC_CRC_EN
      crc_q         <= crc_d;
      crc_error_q   <= crc_error_d;
`endif
    end
  end

  adc_sample_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (system_clock),
    .reset_i     (reset),
    .push_i      (push_q),
    .push_data_i ({push_chan_q, sample_sext}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign {sample_chan, sample_data} = fifo_head;
  assign sample_valid = !fifo_empty;
  assign status_word  = status_word_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign overflow     = overflow_q;
`ifdef ADC_CRC_EN
  assign crc_error    = crc_error_q;
`else
  assign crc_error    = 1'b0;
`endif

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - directed self-checking bench for adc_frame_capture (ADC_CRC_EN optional)
module tb_adc_frame_capture;

  logic        system_clock = 1'b0;
  logic        reset        = 1'b1;
  logic        spi_sclk     = 1'b0;
  logic        spi_cs       = 1'b1;
  logic        spi_miso     = 1'b0;
  logic        sample_ready = 1'b0;
  logic [31:0] sample_data;
  logic [1:0]  sample_chan;
  logic        sample_valid;
  logic [15:0] status_word;
  logic        frame_done, frame_error, overflow, crc_error;

  adc_frame_capture dut (
    .system_clock (system_clock),
    .reset        (reset),
    .spi_sclk     (spi_sclk),
    .spi_cs       (spi_cs),
    .spi_miso     (spi_miso),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .status_word  (status_word),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .overflow     (overflow),
    .crc_error    (crc_error)
  );

  always #10 system_clock = ~system_clock;

  typedef struct {
    logic [23:0] word;
    logic [31:0] exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t        vecs[8];
  logic [23:0] st_in[2];
  logic [15:0] st_exp[2];

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_err = 0, n_crc = 0, n_crc_alone = 0;
  logic [33:0] popq[$];

  always @(negedge system_clock) begin
    if (frame_done) n_done++;
    if (frame_error) n_err++;
    if (crc_error) begin
      n_crc++;
      if (!frame_done) n_crc_alone++;
    end
    if (!reset && sample_valid && sample_ready) popq.push_back({sample_chan, sample_data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge system_clock);
      #5;
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_miso = b;
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [23:0] w, input int nb);
    for (int i = 23; i > 23 - nb; i--) spi_bit(w[i]);
  endtask

`ifdef ADC_CRC_EN
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [23:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      fb = r[15] ^ w[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  task automatic send_frame(input logic [23:0] st, input logic [95:0] ch, input bit corrupt);
    logic [23:0] w;
`ifdef ADC_CRC_EN
    logic [15:0] crc;
    crc = ref_crc(16'hFFFF, st);
`endif
    spi_cs = 1'b0;
    tick(4);
    send_bits(st, 24);
    for (int c = 0; c < 4; c++) begin
      w = ch[c*24 +: 24];
`ifdef ADC_CRC_EN
      crc = ref_crc(crc, w);
`endif
      if (corrupt && c == 3) w[0] = ~w[0];
      send_bits(w, 24);
    end
`ifdef ADC_CRC_EN
    send_bits({crc, 8'h00}, 24);
`endif
    tick(4);
    spi_cs = 1'b1;
    tick(10);
  endtask

  function automatic logic [95:0] seq4(input logic [23:0] base);
    return {base + 24'd3, base + 24'd2, base + 24'd1, base};
  endfunction

  task automatic wait_pops(input int n, input string name);
    int budget;
    budget = 4000;
    while (popq.size() < n && budget > 0) begin
      tick(1);
      budget--;
    end
    check(name, popq.size(), n);
  endtask

  task automatic drain(input int n, input string name);
    int budget;
    budget = 200;
    sample_ready = 1'b1;
    while (sample_valid && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(2);
    check(name, popq.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  int          d0, e0, c0;
  logic [23:0] w;

  initial begin
    vecs[0] = '{24'h7FFFFF, 32'h007FFFFF, 2'd0};
    vecs[1] = '{24'h800000, 32'hFF800000, 2'd1};
    vecs[2] = '{24'h000001, 32'h00000001, 2'd2};
    vecs[3] = '{24'hFFFFFF, 32'hFFFFFFFF, 2'd3};
    vecs[4] = '{24'h123456, 32'h00123456, 2'd0};
    vecs[5] = '{24'hABCDEF, 32'hFFABCDEF, 2'd1};
    vecs[6] = '{24'h000000, 32'h00000000, 2'd2};
    vecs[7] = '{24'h400000, 32'h00400000, 2'd3};
    st_in[0] = 24'h220000; st_exp[0] = 16'h2200;
    st_in[1] = 24'hA5C311; st_exp[1] = 16'hA5C3;

    tick(4);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_chan", sample_chan, 0);
    check("rst_status", status_word, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_crc_error", crc_error, 0);
    reset = 1'b0;
    tick(4);

    // Sign extension and channel tagging, two frames from the vector table
    sample_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      d0 = n_done;
      popq.delete();
      send_frame(st_in[f], {vecs[f*4+3].word, vecs[f*4+2].word, vecs[f*4+1].word, vecs[f*4].word}, 1'b0);
      wait_pops(4, "frame_pop_count");
      for (int c = 0; c < 4; c++)
        check("sample", popq[c], {vecs[f*4+c].exp_chan, vecs[f*4+c].exp_data});
      check("status_word", status_word, st_exp[f]);
      check("frame_done_pulses", n_done - d0, 1);
    end

    // Overflow: three frames into an 8-deep FIFO with no consumer
    sample_ready = 1'b0;
    popq.delete();
    d0 = n_done;
    for (int f = 0; f < 3; f++) send_frame(24'h0F0000, seq4(24'h800000 + 24'(f * 16)), 1'b0);
    check("ovf_frames", n_done - d0, 3);
    check("ovf_flag", overflow, 1);
    drain(8, "ovf_drain_count");
    for (int k = 0; k < 8; k++)
      check("ovf_order", popq[k], {2'(k % 4), 8'hFF, 24'h800000 + 24'((k / 4) * 16 + k % 4)});
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared", overflow, 0);
    check("reset_status", status_word, 0);

    // Push into a full FIFO in the very cycle the consumer pops
    sample_ready = 1'b0;
    popq.delete();
    e0 = n_err;
    send_frame(24'h5A5A00, seq4(24'h0000A0), 1'b0);
    send_frame(24'h3C3C00, seq4(24'h0000B0), 1'b0);
    check("full_no_ovf", overflow, 0);
    spi_cs = 1'b0;
    tick(4);
    send_bits(24'h3C3C00, 24);
    send_bits(24'h0000C0, 23);
    spi_miso = 1'b0;
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
    tick(2);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    tick(4);
    spi_cs = 1'b1;
    tick(10);
    check("simul_no_ovf", overflow, 0);
    check("simul_one_pop", popq.size(), 1);
    check("simul_abort", n_err - e0, 1);
    drain(9, "simul_count");
    for (int k = 1; k < 9; k++) begin
      w = (k < 4) ? 24'h0000A0 + 24'(k) : (k < 8) ? 24'h0000B0 + 24'(k - 4) : 24'h0000C0;
      check("simul_order", popq[k], {2'(k % 4), 8'h00, w});
    end
    check("simul_status", status_word, 16'h3C3C);

    // Abort after 10 bits of channel 2
    sample_ready = 1'b1;
    popq.delete();
    e0 = n_err;
    d0 = n_done;
    spi_cs = 1'b0;
    tick(4);
    send_bits(24'h111100, 24);
    send_bits(24'h000010, 24);
    send_bits(24'hFFFF11, 24);
    send_bits(24'h000012, 10);
    tick(4);
    spi_cs = 1'b1;
    tick(10);
    check("abort_error_pulses", n_err - e0, 1);
    check("abort_no_done", n_done - d0, 0);
    check("abort_kept_count", popq.size(), 2);
    check("abort_ch0", popq[0], {2'd0, 32'h00000010});
    check("abort_ch1", popq[1], {2'd1, 32'hFFFFFF11});
    check("abort_status_kept", status_word, 16'h3C3C);
    popq.delete();
    send_frame(24'h777700, seq4(24'h000020), 1'b0);
    wait_pops(4, "after_abort_count");
    for (int c = 0; c < 4; c++) check("after_abort", popq[c], {2'(c), 32'h00000020 + 32'(c)});
    check("after_abort_status", status_word, 16'h7777);

    // Reset in the middle of channel 1 while CS stays low
    sample_ready = 1'b0;
    popq.delete();
    e0 = n_err;
    d0 = n_done;
    spi_cs = 1'b0;
    tick(4);
    send_bits(24'h999900, 24);
    send_bits(24'h000030, 24);
    send_bits(24'h000031, 12);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    send_bits(24'h031000, 12);
    send_bits(24'h000032, 24);
    send_bits(24'h000033, 24);
    tick(4);
    spi_cs = 1'b1;
    tick(10);
    check("rstmid_no_error", n_err - e0, 0);
    check("rstmid_no_done", n_done - d0, 0);
    check("rstmid_empty", sample_valid, 0);
    check("rstmid_status", status_word, 0);
    send_frame(24'hABCD00, seq4(24'h000040), 1'b0);
    drain(4, "rstmid_count");
    for (int c = 0; c < 4; c++) check("rstmid_sample", popq[c], {2'(c), 32'h00000040 + 32'(c)});
    check("rstmid_new_status", status_word, 16'hABCD);

`ifdef ADC_CRC_EN
    sample_ready = 1'b1;
    c0 = n_crc;
    d0 = n_done;
    send_frame(24'h220000, {24'hFFFFFF, 24'h000001, 24'h800000, 24'h7FFFFF}, 1'b0);
    check("crc_good_no_error", n_crc - c0, 0);
    check("crc_good_done", n_done - d0, 1);
    send_frame(24'h220000, {24'hFFFFFF, 24'h000001, 24'h800000, 24'h7FFFFF}, 1'b1);
    check("crc_bad_error", n_crc - c0, 1);
    check("crc_bad_done", n_done - d0, 2);
    check("crc_with_done", n_crc_alone, 0);
    check("crc_bad_status", status_word, 16'h2200);
`else
    check("crc_error_tied", n_crc, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
